cache_init_sequencer: RTL and testbench
=======================================

Name: cache_init_sequencer

Overview:
Consumes the power-on `launch` level and the DRAM-ready level. Once both are high, sweeps every cache-line index once and writes an all-zero entry (valid=0, dirty=0, tag=0) into the tag RAM. Then raises `init_done`, which gates the cache front-end. After initialisation it also serves full-flush (invalidate-all) requests over a level req/ack handshake, reusing the same sweep.

Parameters:
INDEX_WIDTH, 8, log2 of cache line count; sweep length is 2^INDEX_WIDTH cycles.
TAG_WIDTH, 14, tag field width; tag RAM entry is TAG_WIDTH+2 bits {valid, dirty, tag}.

Ports:
clk  input  1  system clock, all logic on rising edge.
rstn  input  1  reset, asynchronous assert, active-low; deassertion is externally synchronised.
launch  input  1  start-permission level from the power-on delay counter; sticky high once asserted.
mem_ready  input  1  DRAM controller calibration-complete level.
flush_req  input  1  invalidate-all request, level, held until flush_ack.
flush_ack  output  1  one-cycle pulse: flush sweep finished.
tag_we  output  1  tag RAM write enable.
tag_waddr  output  INDEX_WIDTH  tag RAM write index.
tag_wdata  output  TAG_WIDTH+2  tag RAM write data, constant zero.
init_done  output  1  high when no sweep is running and the initial sweep has completed.

Behaviour:
- All outputs registered; tag_wdata tied to zero.
- Reset (rstn low, async): state=WAIT, idx=0, tag_we=0, tag_waddr=0, init_done=0, flush_ack=0, is_flush=0. All take effect immediately, without a clock edge.
- States: WAIT, CLEAR, DONE.
- WAIT:
  - Outputs idle.
  - On an edge where launch & mem_ready = 1: go to CLEAR, is_flush=0.
  - Either input low: stay in WAIT.
- CLEAR:
  - Each cycle: tag_we=1, tag_waddr=idx, idx increments by 1.
  - First write is visible the cycle after the triggering edge.
  - Writes are exactly 2^INDEX_WIDTH, addresses 0..2^INDEX_WIDTH-1 ascending, with no gaps.
  - After the write at max index: idx wraps to 0, next cycle tag_we=0, state=DONE, init_done=1.
  - flush_ack=is_flush in that same cycle, for one cycle.
- DONE:
  - On an edge where flush_req=1: go to CLEAR, is_flush=1, init_done drops in the first write cycle.
- Handshake: the requester must drop flush_req in the cycle flush_ack is high. If flush_req is still high on the following edge, a new flush starts (not an error).
- Ignored inputs:
  - launch or mem_ready falling in CLEAR or DONE: no effect.
  - flush_req in WAIT or CLEAR: ignored, not queued. The requester keeps holding it and it is served on entering DONE. A flush_req held through the initial sweep therefore causes a second sweep right after init_done rises (init_done high for 1 cycle).
- Total latency, trigger edge to init_done high: 2^INDEX_WIDTH + 1 cycles.
- Reset mid-CLEAR: sweep is abandoned and the next trigger restarts from index 0.
- Index arithmetic is unsigned INDEX_WIDTH-bit with natural wrap; there is no separate terminal counter.

Decomposition:
- Shared cache package holds:
  - state enum {WAIT, CLEAR, DONE};
  - tag-entry field layout constants (VALID_BIT = TAG_WIDTH+1, DIRTY_BIT = TAG_WIDTH);
  - INDEX_WIDTH/TAG_WIDTH defaults shared with the cache core.
- No sub-module needed; the sweep counter stays inline. If needed, a thin `index_sweeper` (enable, count, last flag) may be factored out for reuse by a future writeback-all sequencer.

Test Plan:
- Bench parameters INDEX_WIDTH=4, TAG_WIDTH=14; all checks cycle-exact.
1. Reset, launch=1, mem_ready=0 for 50 cycles -> tag_we never 1, init_done=0.
2. From scenario 1, raise mem_ready at edge T -> tag_we=1 on cycles T+1..T+16 with tag_waddr=0..15, tag_wdata=0. Then init_done=1 at T+17, flush_ack stays 0.
3. In DONE, hold flush_req until ack -> init_done drops next cycle, 16 writes 0..15 follow, then flush_ack=1 for exactly 1 cycle together with init_done rising. flush_req dropped in that cycle -> tag_we stays 0 afterwards.
4. Assert flush_req during the initial sweep (cycle T+5) and hold it -> initial sweep completes unchanged, flush_ack=0 at its end. A second 16-write sweep begins right after, and flush_ack=1 at its end.
5. Pull rstn low asynchronously mid-cycle during the write at index 7 -> tag_we and init_done go 0 before the next edge. After release with launch & mem_ready high, the sweep restarts at index 0 and performs 16 writes.
6. Drop launch and mem_ready in DONE -> init_done stays 1, no writes occur.

Source files
------------

// File: rtl/cache_init_sequencer_pkg.sv
// Shared cache definitions: sequencer states, tag-entry layout, default geometry.
// Imported by the init sequencer and the cache core so both agree on entry format.
package cache_init_sequencer_pkg;

    localparam int INDEX_WIDTH_DEF = 8;
    localparam int TAG_WIDTH_DEF   = 14;

    // Tag RAM entry is {valid, dirty, tag}
    localparam int VALID_BIT = TAG_WIDTH_DEF + 1;
    localparam int DIRTY_BIT = TAG_WIDTH_DEF;

    typedef enum logic [1:0] {
        WAIT  = 2'd0,
        CLEAR = 2'd1,
        DONE  = 2'd2
    } seq_state_t;

    function automatic int entry_width(input int tag_width);
        return tag_width + 2;
    endfunction

endpackage

// File: rtl/cache_init_sequencer_if.sv
// Start/flush handshake and tag-RAM write port of the cache init sequencer.
// master = sequencer side, slave = environment (power-on logic, flush requester, tag RAM).
interface cache_init_sequencer_if
    import cache_init_sequencer_pkg::*;
#(
    parameter int INDEX_WIDTH = INDEX_WIDTH_DEF,
    parameter int TAG_WIDTH   = TAG_WIDTH_DEF
);
    logic                   launch;
    logic                   mem_ready;
    logic                   flush_req;
    logic                   flush_ack;
    logic                   tag_we;
    logic [INDEX_WIDTH-1:0] tag_waddr;
    logic [TAG_WIDTH+1:0]   tag_wdata;
    logic                   init_done;

    modport master (
        input  launch,
        input  mem_ready,
        input  flush_req,
        output flush_ack,
        output tag_we,
        output tag_waddr,
        output tag_wdata,
        output init_done
    );

    modport slave (
        output launch,
        output mem_ready,
        output flush_req,
        input  flush_ack,
        input  tag_we,
        input  tag_waddr,
        input  tag_wdata,
        input  init_done
    );

endinterface

// File: rtl/cache_init_sequencer.sv
// Clears every tag RAM line after power-on (launch & mem_ready), then serves invalidate-all flushes.
// Latency: first write one cycle after trigger edge, init_done 2^INDEX_WIDTH+1 cycles after it.
// Backpressure: none; flush_req is a level held until flush_ack, ignored outside DONE.
module cache_init_sequencer
    import cache_init_sequencer_pkg::*;
#(
    parameter int INDEX_WIDTH = INDEX_WIDTH_DEF,
    parameter int TAG_WIDTH   = TAG_WIDTH_DEF
)
(
    input  logic                   clk,
    input  logic                   rstn,
    cache_init_sequencer_if.master bus
);

    localparam logic [INDEX_WIDTH-1:0] IDX_MAX = '1;

    seq_state_t             state;
    seq_state_t             state_nxt;
    logic [INDEX_WIDTH-1:0] idx;
    logic [INDEX_WIDTH-1:0] idx_nxt;
    logic                   is_flush;
    logic                   is_flush_nxt;

    logic                   tag_we_q;
    logic                   tag_we_nxt;
    logic [INDEX_WIDTH-1:0] tag_waddr_q;
    logic [INDEX_WIDTH-1:0] tag_waddr_nxt;
    logic                   init_done_q;
    logic                   init_done_nxt;
    logic                   flush_ack_q;
    logic                   flush_ack_nxt;

    // Cleared entry: valid=0, dirty=0, tag=0
    logic [TAG_WIDTH+1:0]   entry_clear;
    assign entry_clear = {1'b0, 1'b0, {TAG_WIDTH{1'b0}}};

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state       <= WAIT;
            idx         <= '0;
            is_flush    <= 1'b0;
            tag_we_q    <= 1'b0;
            tag_waddr_q <= '0;
            init_done_q <= 1'b0;
            flush_ack_q <= 1'b0;
        end else begin
            state       <= state_nxt;
            idx         <= idx_nxt;
            is_flush    <= is_flush_nxt;
            tag_we_q    <= tag_we_nxt;
            tag_waddr_q <= tag_waddr_nxt;
            init_done_q <= init_done_nxt;
            flush_ack_q <= flush_ack_nxt;
        end
    end

    // idx is the address presented in the current CLEAR cycle; it wraps to 0 after the last line,
    // so a following flush sweep starts from 0 without a separate clear.
    always_comb begin
        state_nxt    = state;
        idx_nxt      = idx;
        is_flush_nxt = is_flush;
        case (state)
            WAIT: begin
                if (bus.launch && bus.mem_ready) begin
                    state_nxt    = CLEAR;
                    is_flush_nxt = 1'b0;
                end
            end
            CLEAR: begin
                idx_nxt = idx + 1'b1;
                if (idx == IDX_MAX) begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                if (bus.flush_req) begin
                    state_nxt    = CLEAR;
                    is_flush_nxt = 1'b1;
                end
            end
            default: begin
                state_nxt = WAIT;
                idx_nxt   = '0;
            end
        endcase
    end

    // Outputs are computed from the next state and registered, so they line up with state.
    always_comb begin
        tag_we_nxt    = 1'b0;
        tag_waddr_nxt = '0;
        init_done_nxt = 1'b0;
        flush_ack_nxt = 1'b0;
        if (state_nxt == CLEAR) begin
            tag_we_nxt    = 1'b1;
            tag_waddr_nxt = idx_nxt;
        end
        if (state_nxt == DONE) begin
            init_done_nxt = 1'b1;
        end
        if (state == CLEAR && state_nxt == DONE) begin
            flush_ack_nxt = is_flush;
        end
    end

    assign bus.tag_we    = tag_we_q;
    assign bus.tag_waddr = tag_waddr_q;
    assign bus.tag_wdata = entry_clear;
    assign bus.init_done = init_done_q;
    assign bus.flush_ack = flush_ack_q;

endmodule

// File: tb/tb_cache_init_sequencer.sv
// Directed, cycle-exact bench for cache_init_sequencer with 16 cache lines.
module tb_cache_init_sequencer;

    localparam int IW    = 4;
    localparam int TW    = 14;
    localparam int LINES = 1 << IW;

    logic clk;
    logic rstn;

    int compared;
    int mismatched;

    cache_init_sequencer_if #(.INDEX_WIDTH(IW), .TAG_WIDTH(TW)) bus ();

    cache_init_sequencer #(.INDEX_WIDTH(IW), .TAG_WIDTH(TW)) dut (
        .clk  (clk),
        .rstn (rstn),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_idle(input string tag, input logic exp_done);
        chk({tag, ".tag_we"},    32'(bus.tag_we),    32'd0);
        chk({tag, ".init_done"}, 32'(bus.init_done), 32'(exp_done));
        chk({tag, ".flush_ack"}, 32'(bus.flush_ack), 32'd0);
    endtask

    // Called at the negedge before the trigger edge. Checks 16 writes and the completion cycle;
    // returns at the completion cycle's negedge. raise_at >= 0 asserts flush_req after that write.
    task automatic sweep(input string tag, input logic exp_ack, input int raise_at);
        for (int i = 0; i < LINES; i++) begin
            @(negedge clk);
            chk({tag, ".we"},    32'(bus.tag_we),    32'd1);
            chk({tag, ".addr"},  32'(bus.tag_waddr), 32'(i));
            chk({tag, ".wdata"}, 32'(bus.tag_wdata), 32'd0);
            chk({tag, ".done"},  32'(bus.init_done), 32'd0);
            chk({tag, ".ack"},   32'(bus.flush_ack), 32'd0);
            if (i == raise_at) bus.flush_req = 1'b1;
        end
        @(negedge clk);
        chk({tag, ".end_we"},   32'(bus.tag_we),    32'd0);
        chk({tag, ".end_done"}, 32'(bus.init_done), 32'd1);
        chk({tag, ".end_ack"},  32'(bus.flush_ack), 32'(exp_ack));
    endtask

    initial begin
        compared       = 0;
        mismatched     = 0;
        rstn           = 1'b0;
        bus.launch     = 1'b0;
        bus.mem_ready  = 1'b0;
        bus.flush_req  = 1'b0;

        // Reset state
        repeat (3) @(negedge clk);
        chk_idle("reset", 1'b0);
        chk("reset.addr", 32'(bus.tag_waddr), 32'd0);
        rstn = 1'b1;

        // 1: launch alone must not start the sweep
        bus.launch = 1'b1;
        repeat (50) begin
            @(negedge clk);
            chk_idle("wait_launch_only", 1'b0);
        end

        // 2: mem_ready completes the trigger -> initial sweep, no ack
        bus.mem_ready = 1'b1;
        sweep("init", 1'b0, -1);
        repeat (3) begin
            @(negedge clk);
            chk_idle("done_idle", 1'b1);
        end

        // 3: flush held until ack, dropped in the ack cycle
        bus.flush_req = 1'b1;
        sweep("flush", 1'b1, -1);
        bus.flush_req = 1'b0;
        repeat (4) begin
            @(negedge clk);
            chk_idle("after_flush", 1'b1);
        end

        // 6: launch/mem_ready falling in DONE has no effect
        bus.launch    = 1'b0;
        bus.mem_ready = 1'b0;
        repeat (5) begin
            @(negedge clk);
            chk_idle("done_inputs_low", 1'b1);
        end

        // 4: flush_req raised during the initial sweep is served right after it
        rstn = 1'b0;
        @(negedge clk);
        chk_idle("reset2", 1'b0);
        rstn = 1'b1;
        @(negedge clk);
        chk_idle("wait2", 1'b0);
        bus.launch    = 1'b1;
        bus.mem_ready = 1'b1;
        sweep("init_with_req", 1'b0, 3);
        sweep("queued_flush", 1'b1, -1);
        bus.flush_req = 1'b0;
        repeat (2) begin
            @(negedge clk);
            chk_idle("after_queued", 1'b1);
        end

        // 5: async reset mid-sweep at index 7, then restart from 0
        bus.flush_req = 1'b1;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            chk("abort.we",   32'(bus.tag_we),    32'd1);
            chk("abort.addr", 32'(bus.tag_waddr), 32'(i));
        end
        bus.flush_req = 1'b0;
        #2 rstn = 1'b0;
        #1;
        chk("async.we",   32'(bus.tag_we),    32'd0);
        chk("async.done", 32'(bus.init_done), 32'd0);
        chk("async.addr", 32'(bus.tag_waddr), 32'd0);
        @(negedge clk);
        chk_idle("async_held", 1'b0);
        rstn = 1'b1;
        sweep("restart", 1'b0, -1);
        repeat (2) begin
            @(negedge clk);
            chk_idle("restart_idle", 1'b1);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
